// File: rtl/countdown_timer.sv
// countdown_timer
//   BCD minutes:seconds countdown timer. A preset (00:00-59:59) is loaded
//   with i_ld and counts down one second per i_en tick while running.
//   Reaching 00:00 raises o_done for ALARM_TICKS further ticks, or until
//   i_start acknowledges it. Input priority each cycle: i_cr > i_ld >
//   i_start > i_en.
//
// Parameters
//   ALARM_TICKS  number of i_en ticks o_done stays high after expiry (1-255)
// Ports
//   i_cp      clock, rising edge
//   i_cr      synchronous active-high reset
//   i_en      1 Hz tick, one i_cp cycle wide
//   i_ld      load preset (level-sampled)
//   i_start   start / pause / acknowledge strobe, one cycle wide
//   i_d_min   preset minutes, packed BCD {tens, units}
//   i_d_sec   preset seconds, packed BCD
//   o_q_min   current minutes, packed BCD
//   o_q_sec   current seconds, packed BCD
//   o_run     high in RUN state only
//   o_done    alarm flag, high in ALARM state only
module countdown_timer #(
  parameter int ALARM_TICKS = 10
) (
  input  logic       i_cp,
  input  logic       i_cr,
  input  logic       i_en,
  input  logic       i_ld,
  input  logic       i_start,
  input  logic [7:0] i_d_min,
  input  logic [7:0] i_d_sec,
  output logic [7:0] o_q_min,
  output logic [7:0] o_q_sec,
  output logic       o_run,
  output logic       o_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam logic [7:0] ALARM_TICKS_W = 8'(ALARM_TICKS);

  // Clamp one packed-BCD byte: tens limited to 5, units limited to 9.
  function automatic logic [7:0] sanitise(input logic [7:0] bcd);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = (bcd[7:4] > 4'd5) ? 4'd5 : bcd[7:4];
    units = (bcd[3:0] > 4'd9) ? 4'd9 : bcd[3:0];
    return {tens, units};
  endfunction

  // One-second BCD decrement of {min, sec}. Borrow ripples sec-units ->
  // sec-tens -> min-units -> min-tens. 00:00 is returned unchanged so the
  // count can never underflow.
  function automatic logic [15:0] dec_bcd(input logic [7:0] mn, input logic [7:0] sc);
    logic [3:0] su;
    logic [3:0] st;
    logic [3:0] mu;
    logic [3:0] mt;
    {mt, mu} = mn;
    {st, su} = sc;
    if ((mn == 8'h00) && (sc == 8'h00)) begin
      return {mn, sc};
    end else begin
      if (su != 4'd0) begin
        su = su - 4'd1;
      end else begin
        su = 4'd9;
        if (st != 4'd0) begin
          st = st - 4'd1;
        end else begin
          st = 4'd5;
          if (mu != 4'd0) begin
            mu = mu - 4'd1;
          end else begin
            mu = 4'd9;
            mt = mt - 4'd1;
          end
        end
      end
      return {mt, mu, st, su};
    end
  endfunction

  state_t     r_state;
  logic [7:0] r_min;
  logic [7:0] r_sec;
  logic [7:0] r_cnt;
  logic       r_run;
  logic       r_done;

  state_t     w_state_nxt;
  logic [7:0] w_min_nxt;
  logic [7:0] w_sec_nxt;
  logic [7:0] w_cnt_nxt;
  logic [7:0] w_cnt_inc;
  logic [15:0] w_dec;
  logic       w_zero;
  logic       w_one;

  assign w_dec     = dec_bcd(r_min, r_sec);
  assign w_zero    = (r_min == 8'h00) && (r_sec == 8'h00);
  assign w_one     = (r_min == 8'h00) && (r_sec == 8'h01);
  assign w_cnt_inc = r_cnt + 8'd1;

  // Next-state, next-count and alarm-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    w_cnt_nxt   = r_cnt;
    if (i_ld) begin
      // Load wins over START/EN and always lands in IDLE.
      w_min_nxt   = sanitise(i_d_min);
      w_sec_nxt   = sanitise(i_d_sec);
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start && !w_zero) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (i_start) begin
            w_state_nxt = ST_PAUSE;
          end else if (i_en) begin
            {w_min_nxt, w_sec_nxt} = w_dec;
            w_cnt_nxt = 8'd0;
            // Expiry enters ALARM on the same edge that shows 00:00.
            if (w_one) begin
              w_state_nxt = ST_ALARM;
            end else begin
              w_state_nxt = ST_RUN;
            end
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (i_start) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_PAUSE;
          end
        end
        ST_ALARM: begin
          if (i_start) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 8'd0;
          end else if (i_en) begin
            if (w_cnt_inc >= ALARM_TICKS_W) begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = 8'd0;
            end else begin
              w_cnt_nxt   = w_cnt_inc;
            end
          end else begin
            w_state_nxt = ST_ALARM;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  // State, count and registered status flags.
  always_ff @(posedge i_cp) begin
    if (i_cr) begin
      r_state <= ST_IDLE;
      r_min   <= 8'h00;
      r_sec   <= 8'h00;
      r_cnt   <= 8'd0;
      r_run   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_min   <= w_min_nxt;
      r_sec   <= w_sec_nxt;
      r_cnt   <= w_cnt_nxt;
      r_run   <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_ALARM);
    end
  end

  assign o_q_min = r_min;
  assign o_q_sec = r_sec;
  assign o_run   = r_run;
  assign o_done  = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer
//   Directed bench for countdown_timer with ALARM_TICKS = 10. Each step
//   drives inputs, takes one rising edge and inspects outputs 1 ns later.
module tb_countdown_timer;

  logic       cp;
  logic       cr;
  logic       en;
  logic       ld;
  logic       start;
  logic [7:0] d_min;
  logic [7:0] d_sec;
  logic [7:0] q_min;
  logic [7:0] q_sec;
  logic       run;
  logic       done;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.ALARM_TICKS(10)) dut (
    .i_cp    (cp),
    .i_cr    (cr),
    .i_en    (en),
    .i_ld    (ld),
    .i_start (start),
    .i_d_min (d_min),
    .i_d_sec (d_sec),
    .o_q_min (q_min),
    .o_q_sec (q_sec),
    .o_run   (run),
    .o_done  (done)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  // One clock step with the given inputs; inputs return to idle afterwards.
  task automatic step(input logic a_cr, input logic a_ld, input logic a_start,
                      input logic a_en, input logic [7:0] a_min, input logic [7:0] a_sec);
    cr = a_cr; ld = a_ld; start = a_start; en = a_en; d_min = a_min; d_sec = a_sec;
    @(posedge cp);
    #1;
    cr = 1'b0; ld = 1'b0; start = 1'b0; en = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks count, RUN and DONE together.
  task automatic chk_all(input string tag, input logic [15:0] q, input logic r, input logic d);
    chk({tag, "_q"}, {q_min, q_sec}, q);
    chk({tag, "_run"}, {15'd0, run}, {15'd0, r});
    chk({tag, "_done"}, {15'd0, done}, {15'd0, d});
  endtask

  initial begin
    cr = 1'b1; ld = 1'b0; start = 1'b0; en = 1'b0; d_min = 8'h00; d_sec = 8'h00;
    #2;
    // Reset for two cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk_all("reset", 16'h0000, 1'b0, 1'b0);
    // START/EN at 00:00 are ignored.
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    chk_all("zero_start", 16'h0000, 1'b0, 1'b0);

    // 10:00 -> 09:59.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    chk_all("ld_1000", 16'h1000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk("idle_en_ignored", {q_min, q_sec}, 16'h1000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk_all("start_1000", 16'h1000, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk_all("dec_0959", 16'h0959, 1'b1, 1'b0);

    // 01:00 -> 00:59.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk_all("dec_0059", 16'h0059, 1'b1, 1'b0);

    // 00:10 -> 00:09.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk_all("dec_0009", 16'h0009, 1'b1, 1'b0);

    // Expiry from 00:03 and a 10-tick alarm.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h03);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk_all("exp_0002", 16'h0002, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk_all("exp_0001", 16'h0001, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk_all("expired", 16'h0000, 1'b0, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    end
    chk_all("alarm_tick9", 16'h0000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk_all("alarm_tick10", 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk_all("post_alarm_start", 16'h0000, 1'b0, 1'b0);

    // Pause/resume collisions from 00:05.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h05);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk_all("run_0005", 16'h0005, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    chk_all("pause", 16'h0005, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk_all("pause_hold", 16'h0005, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    chk_all("resume", 16'h0005, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk_all("resume_dec", 16'h0004, 1'b1, 1'b0);

    // LD beats START/EN in RUN and is sanitised.
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h7C, 8'hFA);
    chk_all("ld_prio", 16'h5959, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk_all("ld_prio_idle", 16'h5959, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h3A, 8'h6B);
    chk("sanitise_mix", {q_min, q_sec}, 16'h3959);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 8'h34);
    chk_all("cr_over_ld", 16'h0000, 1'b0, 1'b0);

    // Acknowledge alarm with START.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk_all("ack_expired", 16'h0000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk_all("ack", 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk_all("ack_idle", 16'h0000, 1'b0, 1'b0);

    // Alarm counter restarts from zero on the next expiry.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    end
    chk_all("alarm2_tick9", 16'h0000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk_all("alarm2_tick10", 16'h0000, 1'b0, 1'b0);

    // Mid-run reset at 12:34.
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h12, 8'h34);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    chk_all("run_1234", 16'h1234, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk("dec_1233", {q_min, q_sec}, 16'h1233);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk_all("mid_reset", 16'h0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
